// File: rtl/loop_sequencer.sv
// loop_sequencer: record-and-playback scheduler between the keypad input
// driver and the oscillator. In IDLE and RECORD the live note passes
// through; RECORD also captures each new live note into a small loop store.
// PLAY replays the stored loop at a fixed step rate. A held live key
// overrides playback without disturbing the loop position.
module loop_sequencer #(
   parameter int DEPTH       = 16,
   parameter int STEP_CYCLES = 2500000
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [17:0]               live_divider,
   input  logic                      live_strobe,
   input  logic                      rec_key,
   input  logic                      play_key,
   output logic [17:0]               divider_out,
   output logic                      strobe_out,
   output logic [1:0]                state,
   output logic [$clog2(DEPTH):0]    count,
   output logic [$clog2(DEPTH)-1:0]  play_idx
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [IW-1:0] IDX_ZERO   = IW'(0);
   localparam logic [IW-1:0] IDX_ONE    = IW'(1);
   localparam logic [SW-1:0] STEP_ZERO  = SW'(0);
   localparam logic [SW-1:0] STEP_ONE   = SW'(1);
   localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RECORD = 2'b01;
   localparam logic [1:0] ST_PLAY   = 2'b10;

   // Registered state
   logic [1:0]    state_r;
   logic [CW-1:0] count_r;
   logic [IW-1:0] play_idx_r;
   logic [SW-1:0] step_r;
   logic [17:0]   divider_out_r;
   logic          strobe_out_r;
   logic          rec_prev_r;
   logic          play_prev_r;
   logic          strobe_prev_r;
   logic [17:0]   mem_r [DEPTH];

   // Combinational next values
   logic          rec_rise_s;
   logic          play_rise_s;
   logic          strobe_rise_s;
   logic          capture_s;
   logic [1:0]    state_next_s;
   logic [CW-1:0] count_next_s;
   logic [IW-1:0] play_idx_next_s;
   logic [SW-1:0] step_next_s;
   logic [17:0]   divider_next_s;
   logic          strobe_next_s;

   assign rec_rise_s    = rec_key     & ~rec_prev_r;
   assign play_rise_s   = play_key    & ~play_prev_r;
   assign strobe_rise_s = live_strobe & ~strobe_prev_r;

   // A new live note is stored only while recording and while room remains.
   assign capture_s = (state_r == ST_RECORD) && strobe_rise_s && (count_r < COUNT_FULL);

   // Previous-cycle copies of the buttons and live strobe for rise detection.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         rec_prev_r    <= 1'b0;
         play_prev_r   <= 1'b0;
         strobe_prev_r <= 1'b0;
      end else begin
         rec_prev_r    <= rec_key;
         play_prev_r   <= play_key;
         strobe_prev_r <= live_strobe;
      end
   end

   // Note count: cleared when a fresh recording starts, bumped on each capture.
   always_comb begin
      count_next_s = count_r;
      if (rec_rise_s && (state_r != ST_RECORD)) begin
         count_next_s = COUNT_ZERO;
      end else if (capture_s) begin
         count_next_s = count_r + COUNT_ONE;
      end else begin
         count_next_s = count_r;
      end
   end

   // Next-state logic; rec rise always wins over play rise.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rec_rise_s) begin
               state_next_s = ST_RECORD;
            end else if (play_rise_s && (count_r != COUNT_ZERO)) begin
               state_next_s = ST_PLAY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RECORD: begin
            // A same-cycle capture counts toward the "loop not empty" test.
            if (rec_rise_s) begin
               state_next_s = ST_IDLE;
            end else if (play_rise_s && (count_next_s != COUNT_ZERO)) begin
               state_next_s = ST_PLAY;
            end else begin
               state_next_s = ST_RECORD;
            end
         end
         ST_PLAY: begin
            if (rec_rise_s) begin
               state_next_s = ST_RECORD;
            end else if (play_rise_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_PLAY;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Playback position: the step counter runs continuously in PLAY (even
   // under live override) and advances the slot, wrapping at the last note.
   always_comb begin
      play_idx_next_s = play_idx_r;
      step_next_s     = step_r;
      if ((state_r == ST_PLAY) && (state_next_s == ST_PLAY)) begin
         if (step_r == STEP_LAST) begin
            step_next_s = STEP_ZERO;
            if ({1'b0, play_idx_r} == (count_r - COUNT_ONE)) begin
               play_idx_next_s = IDX_ZERO;
            end else begin
               play_idx_next_s = play_idx_r + IDX_ONE;
            end
         end else begin
            step_next_s     = step_r + STEP_ONE;
            play_idx_next_s = play_idx_r;
         end
      end else begin
         play_idx_next_s = IDX_ZERO;
         step_next_s     = STEP_ZERO;
      end
   end

   // Output selection from the next state so the first PLAY cycle already
   // carries slot 0. A capture implies live_strobe=1, so the override path
   // covers the slot being written on that same edge.
   always_comb begin
      divider_next_s = live_divider;
      strobe_next_s  = live_strobe;
      if (state_next_s == ST_PLAY) begin
         strobe_next_s = 1'b1;
         if (live_strobe) begin
            divider_next_s = live_divider;
         end else begin
            divider_next_s = mem_r[play_idx_next_s];
         end
      end else begin
         divider_next_s = live_divider;
         strobe_next_s  = live_strobe;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Count, playback position and registered outputs.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         count_r       <= COUNT_ZERO;
         play_idx_r    <= IDX_ZERO;
         step_r        <= STEP_ZERO;
         divider_out_r <= 18'd0;
         strobe_out_r  <= 1'b0;
      end else begin
         count_r       <= count_next_s;
         play_idx_r    <= play_idx_next_s;
         step_r        <= step_next_s;
         divider_out_r <= divider_next_s;
         strobe_out_r  <= strobe_next_s;
      end
   end

   // Loop storage; not reset, only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (nrst && capture_s) begin
         mem_r[count_r[IW-1:0]] <= live_divider;
      end
   end

   assign divider_out = divider_out_r;
   assign strobe_out  = strobe_out_r;
   assign state       = state_r;
   assign count       = count_r;
   assign play_idx    = play_idx_r;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer (DEPTH=4, STEP_CYCLES=4).
// Expected outputs are pushed to a scoreboard queue as each cycle's
// stimulus is driven and popped for comparison once the DUT has clocked.
module tb_loop_sequencer;

   localparam int DEPTH       = 4;
   localparam int STEP_CYCLES = 4;
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_REC  = 2'b01;
   localparam logic [1:0] S_PLAY = 2'b10;

   logic        clk;
   logic        nrst;
   logic [17:0] live_divider;
   logic        live_strobe;
   logic        rec_key;
   logic        play_key;
   logic [17:0] divider_out;
   logic        strobe_out;
   logic [1:0]  state;
   logic [2:0]  count;
   logic [1:0]  play_idx;

   typedef struct {
      logic [17:0] div;
      logic        stb;
      logic [1:0]  st;
      logic [2:0]  cnt;
      logic [1:0]  idx;
   } exp_t;

   exp_t        sb_q [$];
   logic [17:0] loop_model [$];
   int          m_idx;
   int          m_step;
   int          checks;
   int          errors;

   loop_sequencer #(
      .DEPTH       (DEPTH),
      .STEP_CYCLES (STEP_CYCLES)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .live_divider (live_divider),
      .live_strobe  (live_strobe),
      .rec_key      (rec_key),
      .play_key     (play_key),
      .divider_out  (divider_out),
      .strobe_out   (strobe_out),
      .state        (state),
      .count        (count),
      .play_idx     (play_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [17:0] d, input logic s, input logic [1:0] st,
                           input int cnt, input int idx);
      exp_t e;
      e.div = d;
      e.stb = s;
      e.st  = st;
      e.cnt = 3'(cnt);
      e.idx = 2'(idx);
      sb_q.push_back(e);
   endtask

   // Advance the bench's own playback position by one clock.
   task automatic advance_model();
      m_step = m_step + 1;
      if (m_step == STEP_CYCLES) begin
         m_step = 0;
         m_idx  = (m_idx + 1) % loop_model.size();
      end
   endtask

   task automatic test_reset();
      exp_t e;
      live_divider = 18'h00100;
      live_strobe  = 1'b1;
      rec_key      = 1'b0;
      play_key     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nrst = (i == 2) ? 1'b1 : 1'b0;
         if (i < 2) push_exp(18'h0, 1'b0, S_IDLE, 0, 0);
         else       push_exp(18'h00100, 1'b1, S_IDLE, 0, 0);
         cyc();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL reset[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     i, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   task automatic test_record();
      exp_t e;
      loop_model.delete();
      for (int i = 0; i < 11; i++) begin
         if (i == 0) begin
            rec_key     = 1'b1;
            live_strobe = 1'b0;
         end else begin
            rec_key      = 1'b0;
            live_divider = 18'h0000A + 18'((i - 1) / 2);
            live_strobe  = ((i - 1) % 2 == 0) ? 1'b1 : 1'b0;
            if (live_strobe && loop_model.size() < DEPTH) loop_model.push_back(live_divider);
         end
         push_exp(live_divider, live_strobe, S_REC, loop_model.size(), 0);
         cyc();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL record[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     i, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   task automatic test_play();
      exp_t e;
      m_idx  = 0;
      m_step = 0;
      for (int c = 0; c < 17; c++) begin
         play_key = (c < 3) ? 1'b1 : 1'b0;
         push_exp(loop_model[m_idx], 1'b1, S_PLAY, loop_model.size(), m_idx);
         cyc();
         advance_model();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL play[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     c, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   task automatic test_override();
      exp_t e;
      live_divider = 18'h001FF;
      for (int c = 0; c < 12; c++) begin
         live_strobe = (c < 6) ? 1'b1 : 1'b0;
         if (c < 6) push_exp(18'h001FF, 1'b1, S_PLAY, loop_model.size(), m_idx);
         else       push_exp(loop_model[m_idx], 1'b1, S_PLAY, loop_model.size(), m_idx);
         cyc();
         advance_model();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL override[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     c, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   // PLAY->IDLE, empty-loop play rise ignored (IDLE and RECORD), rec beats play.
   task automatic test_buttons();
      exp_t e;
      int rec_t [12] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
      int ply_t [12] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
      int st_t  [12] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
      int cnt_t [12] = '{4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      live_divider = 18'h001FF;
      live_strobe  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         rec_key  = rec_t[i][0];
         play_key = ply_t[i][0];
         push_exp(18'h001FF, 1'b0, 2'(st_t[i]), cnt_t[i], 0);
         cyc();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL buttons[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     i, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   // Capture and play rise on the same edge; single-note loop holds forever.
   task automatic test_capture_play();
      exp_t e;
      loop_model.delete();
      for (int c = 0; c < 9; c++) begin
         if (c == 0) begin
            live_divider = 18'h0002A;
            live_strobe  = 1'b1;
            play_key     = 1'b1;
            loop_model.push_back(18'h0002A);
            push_exp(18'h0002A, 1'b1, S_PLAY, 1, 0);
         end else begin
            live_divider = 18'h3FFFF;
            live_strobe  = 1'b0;
            play_key     = 1'b0;
            push_exp(loop_model[0], 1'b1, S_PLAY, 1, 0);
         end
         cyc();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL capture_play[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     c, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   task automatic test_reset_mid_play();
      exp_t e;
      live_divider = 18'h00155;
      live_strobe  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nrst     = (i == 0) ? 1'b0 : 1'b1;
         play_key = (i == 1) ? 1'b1 : 1'b0;
         if (i == 0) push_exp(18'h0, 1'b0, S_IDLE, 0, 0);
         else        push_exp(18'h00155, 1'b0, S_IDLE, 0, 0);
         cyc();
         e = sb_q.pop_front();
         checks++;
         if ({divider_out, strobe_out, state, count, play_idx} !== {e.div, e.stb, e.st, e.cnt, e.idx}) begin
            errors++;
            $display("FAIL reset_mid_play[%0d] got div=%h stb=%b st=%b cnt=%0d idx=%0d expected div=%h stb=%b st=%b cnt=%0d idx=%0d",
                     i, divider_out, strobe_out, state, count, play_idx, e.div, e.stb, e.st, e.cnt, e.idx);
         end
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      nrst         = 1'b0;
      live_divider = 18'h0;
      live_strobe  = 1'b0;
      rec_key      = 1'b0;
      play_key     = 1'b0;
      test_reset();
      test_record();
      test_play();
      test_override();
      test_buttons();
      test_capture_play();
      test_reset_mid_play();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Record-and-playback scheduler that sits between the keypad input driver and the oscillator. It arbitrates the shared divider/strobe path between live keypad notes and a recorded loop of up to DEPTH notes. In RECORD it captures each new live note. In PLAY it replays the loop at a fixed step rate, and live keys override playback.

## Interface
- DEPTH, 16: loop capacity in notes; power of two, ≥2
- STEP_CYCLES, 2500000: clock cycles each played note is held (4 Hz at 10 MHz)
- clk  input  1  system clock; all logic on the rising edge
- nrst  input  1  reset, synchronous, active-low
- live_divider  input  18  divider from the input driver
- live_strobe  input  1  high while a note key is held (from the input driver)
- rec_key  input  1  synchronized record button, level
- play_key  input  1  synchronized play button, level
- divider_out  output  18  divider to the oscillator
- strobe_out  output  1  note-active to the oscillator
- state  output  2  00 IDLE, 01 RECORD, 10 PLAY (11 unused)
- count  output  $clog2(DEPTH)+1  notes stored
- play_idx  output  $clog2(DEPTH)  loop slot currently playing

## Operation
- Edge detection: registered copies of rec_key, play_key and live_strobe. A rise is input=1 and prev=0, evaluated in the same cycle. Prev registers reset to 0.
- Storage: DEPTH x 18 register array. Contents are not reset, and only slots below count are ever read.
- Arbitration: a rec rise has priority over a play rise in every state. State transitions and outputs are fully registered.
- IDLE: divider_out <= live_divider, strobe_out <= live_strobe.
  - rec rise -> RECORD, count <= 0.
  - play rise with count>0 -> PLAY, play_idx <= 0, step counter <= 0.
  - play rise with count==0 is ignored.
- RECORD: pass-through as in IDLE.
  - Each live_strobe rise with count<DEPTH writes mem[count] <= live_divider and increments count.
  - When count==DEPTH (full), further rises are ignored; no wrap and no overwrite.
  - rec rise -> IDLE with count kept.
  - play rise -> PLAY if the next count (including any same-cycle capture) is >0, otherwise stay in RECORD.
- PLAY:
  - live_strobe=1 (override): divider_out <= live_divider, strobe_out <= 1.
  - live_strobe=0: divider_out <= mem[play_idx], strobe_out <= 1.
  - The step counter runs during override. Override never alters play_idx or count.
  - Step counter counts 0..STEP_CYCLES-1. At terminal it resets to 0, and play_idx <= (play_idx==count-1) ? 0 : play_idx+1, so the loop wraps.
  - play rise -> IDLE; play_idx and step counter cleared.
  - rec rise -> RECORD, count <= 0, so a new loop replaces the old one.
- On entry to PLAY, the first registered output is already mem[0] (or the live value if overriding). mem[0] is held STEP_CYCLES cycles.
- count==1 in PLAY: play_idx stays 0 and the note is held indefinitely.

## Timing
- Reset (nrst=0 at a clock edge): state=IDLE, count=0, play_idx=0, step counter=0, divider_out=0, strobe_out=0.
- Reset mid-RECORD or mid-PLAY aborts immediately. The loop is lost (count=0).
- Live pass-through latency: 1 cycle from live_* to the *_out outputs.
- Button latency: a rise sampled at edge k changes state and outputs at edge k. The first affected output is visible after edge k.
- Capture: the divider sampled on the live_strobe rise cycle is stored, and count updates at the same edge.
- Step rate: exactly STEP_CYCLES cycles per slot.
- Simultaneous rec and play rises: rec wins.
- Simultaneous play rise and capture in RECORD: the capture completes, then PLAY is entered.
- Buttons held high produce one action only; a new rise requires a low cycle.

## Test plan
Bench parameters: DEPTH=4, STEP_CYCLES=4.
1. Reset, then hold live_divider=0x00100 with live_strobe=1 -> after reset, outputs are 0. One cycle after release of nrst, divider_out=0x00100, strobe_out=1, state=00.
2. Rec rise, then live_strobe rises with dividers 0x00A, 0x00B, 0x00C, 0x00D, 0x00E -> count ends at 4 (full), and 0x00E is not stored.
3. From scenario 2, play rise -> state=10. divider_out sequence is 0x00A x4, 0x00B x4, 0x00C x4, 0x00D x4, then 0x00A (wrap). play_idx follows 0,1,2,3,0. strobe_out=1 throughout.
4. During PLAY, assert live_strobe with live_divider=0x1FF for 6 cycles, then release -> divider_out=0x1FF for those cycles. Afterwards the output resumes the slot dictated by the uninterrupted step counter.
5. In IDLE with count=0, play rise -> no state change. Then rec and play rise in the same cycle -> state=01, count=0.
6. Mid-PLAY, drive nrst=0 for one cycle -> state=00, count=0, play_idx=0, divider_out=0, strobe_out=0. A subsequent play rise is ignored.
